// File: rtl/gip_rf_wb_ctl_pkg.sv
// Shared definitions for the register-file write-back controller.
// Holds the register-file geometry, the write-back FIFO entry layout and
// the default FIFO depth.
package gip_rf_wb_ctl_pkg;

    localparam int RF_ADDR_W      = 5;
    localparam int RF_DATA_W      = 32;
    localparam int RF_REGS        = 1 << RF_ADDR_W;
    localparam int FIFO_DEPTH_DEF = 4;

    // live is cleared when a newer ALU write to the same register overtakes
    // the queued load, or when the slot is freed.
    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
        logic                 live;
    } wb_entry_t;

endpackage

// File: rtl/gip_rf_wb_ctl_if.sv
// Bus bundle between the pipeline / register file and the write-back
// controller.
//   alu_wb_*    : ALU write-back request (no backpressure)
//   mem_wb_*    : memory load write-back, valid/ready handshake
//   rf_wr_*     : register file write port
//   rd_addr, rf_rd_data, rd_data : read path with forwarding
//   pending     : per-register in-flight scoreboard
// master = pipeline/register-file side, slave = controller.
interface gip_rf_wb_ctl_if;
    import gip_rf_wb_ctl_pkg::*;

    logic                 alu_wb_valid;
    logic [RF_ADDR_W-1:0] alu_wb_addr;
    logic [RF_DATA_W-1:0] alu_wb_data;
    logic                 mem_wb_valid;
    logic [RF_ADDR_W-1:0] mem_wb_addr;
    logic [RF_DATA_W-1:0] mem_wb_data;
    logic                 mem_wb_ready;
    logic                 rf_wr_enable;
    logic [RF_ADDR_W-1:0] rf_wr_addr;
    logic [RF_DATA_W-1:0] rf_wr_data;
    logic [RF_ADDR_W-1:0] rd_addr;
    logic [RF_DATA_W-1:0] rf_rd_data;
    logic [RF_DATA_W-1:0] rd_data;
    logic [RF_REGS-1:0]   pending;

    modport master (
        output alu_wb_valid, alu_wb_addr, alu_wb_data,
        output mem_wb_valid, mem_wb_addr, mem_wb_data,
        input  mem_wb_ready,
        input  rf_wr_enable, rf_wr_addr, rf_wr_data,
        output rd_addr, rf_rd_data,
        input  rd_data, pending
    );

    modport slave (
        input  alu_wb_valid, alu_wb_addr, alu_wb_data,
        input  mem_wb_valid, mem_wb_addr, mem_wb_data,
        output mem_wb_ready,
        output rf_wr_enable, rf_wr_addr, rf_wr_data,
        input  rd_addr, rf_rd_data,
        output rd_data, pending
    );

endinterface

// File: rtl/gip_rf_wb_fifo.sv
// Memory write-back FIFO.
// Ports: rf_clock/rf_reset; push_* enqueue (ignored when full); pop frees
// the head (ignored when empty); kill_* clears the live bit of every queued
// entry with a matching address; fwd_addr searches for the newest live
// match (fwd_hit/fwd_data); live_mask flags registers with a live entry;
// head is the oldest entry.
module gip_rf_wb_fifo
    import gip_rf_wb_ctl_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int PTR_W = 2
) (
    input  logic                 rf_clock,
    input  logic                 rf_reset,
    input  logic                 push,
    input  logic [RF_ADDR_W-1:0] push_addr,
    input  logic [RF_DATA_W-1:0] push_data,
    input  logic                 pop,
    input  logic                 kill_valid,
    input  logic [RF_ADDR_W-1:0] kill_addr,
    input  logic [RF_ADDR_W-1:0] fwd_addr,
    output logic                 full,
    output logic                 empty,
    output wb_entry_t            head,
    output logic                 fwd_hit,
    output logic [RF_DATA_W-1:0] fwd_data,
    output logic [RF_REGS-1:0]   live_mask
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge rf_clock or negedge rf_reset) begin
        if (!rf_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            // Kill only touches entries already queued; a same-cycle push
            // overwrites its (empty) slot below and stays live.
            if (kill_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem[i].addr == kill_addr) mem[i].live <= 1'b0;
                end
            end
            // Freed slots keep live=0 so live_mask and forwarding need no
            // occupancy qualification.
            if (do_pop) begin
                mem[rd_ptr].live <= 1'b0;
                rd_ptr           <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                mem[wr_ptr] <= '{addr: push_addr, data: push_data, live: 1'b1};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Walk oldest to newest so the last match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        fwd_hit   = 1'b0;
        fwd_data  = '0;
        live_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (mem[idx].live && (mem[idx].addr == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem[idx].data;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].live) live_mask[mem[i].addr] = 1'b1;
        end
    end

endmodule

// File: rtl/gip_rf_wb_ctl.sv
// Register-file write-back controller.
// Ports: rf_clock, rf_reset (async, active-low) and the slave side of
// gip_rf_wb_ctl_if. ALU results take the write port whenever present;
// otherwise the memory FIFO head drains. Read data is forwarded from the
// FIFO and the output stage, and pending flags every in-flight write.
module gip_rf_wb_ctl
    import gip_rf_wb_ctl_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int FIFO_PTR_W = 2
) (
    input  logic            rf_clock,
    input  logic            rf_reset,
    gip_rf_wb_ctl_if.slave  bus
);

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    wb_entry_t            head;
    logic                 fwd_hit;
    logic [RF_DATA_W-1:0] fwd_data;
    logic [RF_REGS-1:0]   live_mask;

    logic                 wr_en_q;
    logic [RF_ADDR_W-1:0] wr_addr_q;
    logic [RF_DATA_W-1:0] wr_data_q;

    assign bus.mem_wb_ready = ~full;
    assign push             = bus.mem_wb_valid & ~full;
    assign pop              = ~bus.alu_wb_valid & ~empty;

    gip_rf_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .PTR_W (FIFO_PTR_W)
    ) u_fifo (
        .rf_clock   (rf_clock),
        .rf_reset   (rf_reset),
        .push       (push),
        .push_addr  (bus.mem_wb_addr),
        .push_data  (bus.mem_wb_data),
        .pop        (pop),
        .kill_valid (bus.alu_wb_valid),
        .kill_addr  (bus.alu_wb_addr),
        .fwd_addr   (bus.rd_addr),
        .full       (full),
        .empty      (empty),
        .head       (head),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .live_mask  (live_mask)
    );

    always_ff @(posedge rf_clock or negedge rf_reset) begin
        if (!rf_reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (bus.alu_wb_valid) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= bus.alu_wb_addr;
            wr_data_q <= bus.alu_wb_data;
        end else if (pop) begin
            // A killed entry still drains through here, just without enable.
            wr_en_q   <= head.live;
            wr_addr_q <= head.addr;
            wr_data_q <= head.data;
        end else begin
            wr_en_q   <= 1'b0;
        end
    end

    assign bus.rf_wr_enable = wr_en_q;
    assign bus.rf_wr_addr   = wr_addr_q;
    assign bus.rf_wr_data   = wr_data_q;

    // A live FIFO entry is always younger than the output stage: any older
    // entry would have been killed by the ALU write now in the output stage.
    always_comb begin
        if (fwd_hit)
            bus.rd_data = fwd_data;
        else if (wr_en_q && (wr_addr_q == bus.rd_addr))
            bus.rd_data = wr_data_q;
        else
            bus.rd_data = bus.rf_rd_data;
    end

    assign bus.pending = live_mask | ({RF_REGS{wr_en_q}} & (RF_REGS'(1) << wr_addr_q));

endmodule
